// File: rtl/echo_delay_ctrl.sv
// echo_delay_ctrl
//
// Feedback echo engine for the effects chain. Accepts one signed sample at a
// time, reads the sample written `delay` samples earlier from an external
// single-clock RAM (registered read, one cycle of latency), mixes
//   y = sat(x + floor(d * gain / 2^GAIN_WIDTH))
// writes y back into the RAM at the current write pointer and presents y
// downstream with a valid/ready handshake.
//
// Ports
//   pi_clk          clock, rising edge
//   pi_sreset       synchronous active-high reset
//   pi_delay        echo delay in samples, captured on input accept
//   pi_gain         unsigned feedback gain, captured on input accept
//   pi_valid        input sample valid
//   pi_data         input sample (two's complement)
//   po_ready        block can accept an input sample (IDLE only)
//   po_valid        output sample valid (OUT only)
//   po_data         output sample y, stable while held in OUT
//   pi_ready        downstream accepts the output sample
//   po_ram_wr_en    single-cycle write pulse in the first OUT cycle
//   po_ram_wr_addr  write address (current write pointer)
//   po_ram_wr_data  write data (y)
//   po_ram_rd_en    read enable, high in RD
//   po_ram_rd_addr  read address, wr_ptr - delay with natural wrap
//   pi_ram_rd_data  read data, valid the cycle after po_ram_rd_en

module echo_delay_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int GAIN_WIDTH = 8
) (
  input  logic                  pi_clk,
  input  logic                  pi_sreset,
  input  logic [ADDR_WIDTH-1:0] pi_delay,
  input  logic [GAIN_WIDTH-1:0] pi_gain,
  input  logic                  pi_valid,
  input  logic [DATA_WIDTH-1:0] pi_data,
  output logic                  po_ready,
  output logic                  po_valid,
  output logic [DATA_WIDTH-1:0] po_data,
  input  logic                  pi_ready,
  output logic                  po_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] po_ram_wr_addr,
  output logic [DATA_WIDTH-1:0] po_ram_wr_data,
  output logic                  po_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] po_ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] pi_ram_rd_data
);

  // Product width: signed DATA_WIDTH sample times zero-extended gain.
  localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    MIX,
    OUT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [DATA_WIDTH-1:0] x_q;
  logic [ADDR_WIDTH-1:0]        delay_q;
  logic [GAIN_WIDTH-1:0]        gain_q;
  logic [ADDR_WIDTH-1:0]        wr_ptr_q;
  logic [ADDR_WIDTH-1:0]        fill_cnt_q;
  logic [DATA_WIDTH-1:0]        data_q;
  logic                         wr_en_q;
  logic [ADDR_WIDTH-1:0]        wr_addr_q;
  logic [DATA_WIDTH-1:0]        wr_data_q;

  logic                         accept;
  logic                         out_handshake;

  logic                         echo_masked;
  logic signed [DATA_WIDTH-1:0] d_eff;
  logic signed [PROD_WIDTH-1:0] d_ext;
  logic signed [PROD_WIDTH-1:0] gain_ext;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [PROD_WIDTH-1:0] scaled;
  logic signed [PROD_WIDTH-1:0] x_ext;
  logic signed [PROD_WIDTH-1:0] sum;
  logic                         sum_fits;
  logic [DATA_WIDTH-1:0]        y;

  assign accept        = (state_q == IDLE) && pi_valid;
  assign out_handshake = (state_q == OUT) && pi_ready;

  // State register.
  always_ff @(posedge pi_clk) begin
    if (pi_sreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the state-decoded outputs. The read address is
  // only driven while reading so that it sits at zero otherwise.
  always_comb begin
    state_d        = state_q;
    po_ready       = 1'b0;
    po_valid       = 1'b0;
    po_ram_rd_en   = 1'b0;
    po_ram_rd_addr = '0;
    unique case (state_q)
      IDLE: begin
        po_ready = 1'b1;
        if (pi_valid) begin
          state_d = RD;
        end
      end
      RD: begin
        po_ram_rd_en   = 1'b1;
        po_ram_rd_addr = wr_ptr_q - delay_q;
        state_d        = MIX;
      end
      MIX: begin
        state_d = OUT;
      end
      OUT: begin
        po_valid = 1'b1;
        if (pi_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mix datapath, evaluated while the RAM data is valid in MIX.
  // Until `delay` samples have been written the location read back holds
  // stale data (from before reset or from power-up), so the echo term is
  // forced to zero. A zero delay would read back the location about to be
  // written, which is also meaningless, so it is masked as well.
  // The adder is built at product width rather than DATA_WIDTH+2; both
  // operands are sign-extended and the true sum always fits in DATA_WIDTH+2
  // bits, so the value and the saturation decision are identical.
  always_comb begin
    echo_masked = (delay_q == '0) || (fill_cnt_q < delay_q);
    d_eff       = echo_masked ? '0 : $signed(pi_ram_rd_data);
    d_ext       = $signed({{(PROD_WIDTH - DATA_WIDTH){d_eff[DATA_WIDTH-1]}}, d_eff});
    gain_ext    = $signed({{(PROD_WIDTH - GAIN_WIDTH){1'b0}}, gain_q});
    prod        = d_ext * gain_ext;
    scaled      = prod >>> GAIN_WIDTH;
    x_ext       = $signed({{(PROD_WIDTH - DATA_WIDTH){x_q[DATA_WIDTH-1]}}, x_q});
    sum         = x_ext + scaled;
    sum_fits    = (&sum[PROD_WIDTH-1:DATA_WIDTH-1]) || !(|sum[PROD_WIDTH-1:DATA_WIDTH-1]);
    if (sum_fits) begin
      y = sum[DATA_WIDTH-1:0];
    end else if (sum[PROD_WIDTH-1]) begin
      y = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      y = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end
  end

  // Per-sample parameters are captured at accept, so later changes on the
  // inputs never affect the sample in flight.
  always_ff @(posedge pi_clk) begin
    if (pi_sreset) begin
      x_q     <= '0;
      delay_q <= '0;
      gain_q  <= '0;
    end else if (accept) begin
      x_q     <= $signed(pi_data);
      delay_q <= pi_delay;
      gain_q  <= pi_gain;
    end
  end

  // Result register and write-back. The write strobe is raised on the
  // MIX->OUT transition and cleared one cycle later, giving exactly one
  // pulse in the first OUT cycle however long downstream stalls. A reset
  // while in MIX therefore never produces a write.
  always_ff @(posedge pi_clk) begin
    if (pi_sreset) begin
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (state_q == MIX) begin
        data_q    <= y;
        wr_en_q   <= 1'b1;
        wr_addr_q <= wr_ptr_q;
        wr_data_q <= y;
      end
    end
  end

  // Write pointer advances on the output handshake; fill_cnt counts
  // completed writes and stops at MEM_DEPTH-1, the largest usable delay.
  always_ff @(posedge pi_clk) begin
    if (pi_sreset) begin
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
    end else begin
      if (out_handshake) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (wr_en_q && (fill_cnt_q != FILL_MAX)) begin
        fill_cnt_q <= fill_cnt_q + 1'b1;
      end
    end
  end

  assign po_data        = data_q;
  assign po_ram_wr_en   = wr_en_q;
  assign po_ram_wr_addr = wr_addr_q;
  assign po_ram_wr_data = wr_data_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// tb_echo_delay_ctrl
//
// Self-checking bench for echo_delay_ctrl with a 16-entry delay memory.
// A behavioural single-clock RAM with registered read sits on the RAM port
// and is preloaded with nonzero junk so that warm-up masking is observable.
// Ports: none (top-level bench).

module tb_echo_delay_ctrl;

  localparam int DW = 16;
  localparam int MD = 16;
  localparam int AW = 4;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          sreset;
  logic [AW-1:0] delay;
  logic [GW-1:0] gain;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  logic [DW-1:0] mem [0:MD-1];
  logic          mem_loaded = 1'b0;

  logic [AW-1:0] ptr;
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    logic          rst;
    logic [DW-1:0] x;
    logic [AW-1:0] dly;
    logic [GW-1:0] g;
    logic [DW-1:0] exp_y;
    int            hold;
  } vec_t;

  vec_t main_vecs[$];
  vec_t post_vecs[$];

  always #5 clk = ~clk;

  echo_delay_ctrl #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (MD),
    .ADDR_WIDTH(AW),
    .GAIN_WIDTH(GW)
  ) dut (
    .pi_clk        (clk),
    .pi_sreset     (sreset),
    .pi_delay      (delay),
    .pi_gain       (gain),
    .pi_valid      (in_valid),
    .pi_data       (in_data),
    .po_ready      (in_ready),
    .po_valid      (out_valid),
    .po_data       (out_data),
    .pi_ready      (out_ready),
    .po_ram_wr_en  (ram_wr_en),
    .po_ram_wr_addr(ram_wr_addr),
    .po_ram_wr_data(ram_wr_data),
    .po_ram_rd_en  (ram_rd_en),
    .po_ram_rd_addr(ram_rd_addr),
    .pi_ram_rd_data(ram_rd_data)
  );

  // Single-clock RAM, registered read; filled with junk on the first edge.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MD; i++) begin
        mem[i] <= DW'(16'h5A00 + i * 16'h0111);
      end
      mem_loaded <= 1'b1;
    end else if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
    end
    if (ram_rd_en) begin
      ram_rd_data <= mem[ram_rd_addr];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values();
    check_output("rst_ready",   32'(in_ready),    32'd1);
    check_output("rst_valid",   32'(out_valid),   32'd0);
    check_output("rst_data",    32'(out_data),    32'd0);
    check_output("rst_wr_en",   32'(ram_wr_en),   32'd0);
    check_output("rst_rd_en",   32'(ram_rd_en),   32'd0);
    check_output("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
    check_output("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    check_output("rst_wr_data", 32'(ram_wr_data), 32'd0);
  endtask

  task automatic do_reset();
    sreset   = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    sreset = 1'b0;
    check_reset_values();
    ptr = '0;
  endtask

  // One complete sample: accept, RD, MIX, then `hold` stalled OUT cycles
  // followed by the handshake cycle.
  task automatic apply_stimulus(input logic [DW-1:0] x, input logic [AW-1:0] dly,
                                input logic [GW-1:0] g, input logic [DW-1:0] exp_y,
                                input int hold);
    int waited;
    int pulses;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_rd;
    exp_addr = ptr;
    exp_rd   = ptr - dly;
    waited   = 0;
    while (!in_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_wait actual=0 required=1");
      return;
    end
    in_valid = 1'b1;
    in_data  = x;
    delay    = dly;
    gain     = g;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    delay    = AW'($urandom);
    gain     = GW'($urandom);
    check_output("rd_en",   32'(ram_rd_en),   32'd1);
    check_output("rd_addr", 32'(ram_rd_addr), 32'(exp_rd));
    check_output("rd_ready", 32'(in_ready),   32'd0);
    @(negedge clk);
    check_output("mix_valid", 32'(out_valid), 32'd0);
    check_output("mix_wr_en", 32'(ram_wr_en), 32'd0);
    if (hold > 0) out_ready = 1'b0;
    @(negedge clk);
    pulses = 0;
    for (int c = 0; c <= hold; c++) begin
      check_output("out_valid", 32'(out_valid), 32'd1);
      check_output("out_data",  32'(out_data),  32'(exp_y));
      check_output("out_ready", 32'(in_ready),  32'd0);
      if (ram_wr_en) pulses++;
      if (c == 0) begin
        check_output("wr_en",   32'(ram_wr_en),   32'd1);
        check_output("wr_addr", 32'(ram_wr_addr), 32'(exp_addr));
        check_output("wr_data", 32'(ram_wr_data), 32'(exp_y));
      end
      if (c == hold) out_ready = 1'b1;
      @(negedge clk);
    end
    check_output("wr_pulses",  32'(pulses),    32'd1);
    check_output("post_valid", 32'(out_valid), 32'd0);
    check_output("post_ready", 32'(in_ready),  32'd1);
    check_output("post_wr_en", 32'(ram_wr_en), 32'd0);
    ptr = ptr + 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.rst) do_reset();
    apply_stimulus(v.x, v.dly, v.g, v.exp_y, v.hold);
  endtask

  initial begin
    int yh [0:39];
    int xi;
    int e;
    int s;

    sreset    = 1'b1;
    delay     = '0;
    gain      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    ptr       = '0;

    // Impulse, delay 3, gain 1/2
    main_vecs.push_back('{1'b1, 16'd1000, 4'd3, 8'd128, 16'd1000, 0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd0,    0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd0,    0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd500,  0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd0,    0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd0,    0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd250,  0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd0,    0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd0,    0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd125,  0});
    // Positive saturation: 30000 + floor(30000*255/256)=29882 -> clamp
    main_vecs.push_back('{1'b1, 16'd30000, 4'd1, 8'd255, 16'd30000, 0});
    main_vecs.push_back('{1'b0, 16'd30000, 4'd1, 8'd255, 16'h7FFF,  0});
    // Negative saturation: -30000 + floor(-30000*255/256)=-29883 -> clamp
    main_vecs.push_back('{1'b1, 16'h8AD0, 4'd1, 8'd255, 16'h8AD0, 0});
    main_vecs.push_back('{1'b0, 16'h8AD0, 4'd1, 8'd255, 16'h8000, 0});
    // Floor: d=-1, gain 128 contributes -1, not 0
    main_vecs.push_back('{1'b1, 16'hFFFF, 4'd1, 8'd128, 16'hFFFF, 0});
    main_vecs.push_back('{1'b0, 16'd0,    4'd1, 8'd128, 16'hFFFF, 0});
    // Backpressure with delay 0 (always masked)
    main_vecs.push_back('{1'b1, 16'd1234, 4'd0, 8'd200, 16'd1234, 5});
    main_vecs.push_back('{1'b0, 16'd500,  4'd0, 8'd200, 16'd500,  0});

    // Impulse after a mid-sample reset; pre-reset memory must stay masked
    post_vecs.push_back('{1'b0, 16'd1000, 4'd3, 8'd128, 16'd1000, 0});
    post_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd0,    0});
    post_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd0,    0});
    post_vecs.push_back('{1'b0, 16'd0,    4'd3, 8'd128, 16'd500,  0});

    $display("[TB] table vectors");
    foreach (main_vecs[i]) run_vec(main_vecs[i]);

    $display("[TB] wrap and warm-up, delay 15");
    do_reset();
    for (int n = 0; n < 40; n++) begin
      xi = (n % 8) * 5000 - 15000;
      e  = (n >= 15) ? ((yh[n-15] * 128) >>> 8) : 0;
      s  = xi + e;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      yh[n] = s;
      apply_stimulus(DW'(xi), 4'd15, 8'd128, DW'(s), 0);
    end

    $display("[TB] reset during MIX");
    in_valid = 1'b1;
    in_data  = 16'd7000;
    delay    = 4'd3;
    gain     = 8'd128;
    @(negedge clk);
    in_valid = 1'b0;
    check_output("mr_rd_en", 32'(ram_rd_en), 32'd1);
    @(negedge clk);
    sreset = 1'b1;
    @(negedge clk);
    check_output("mr_valid", 32'(out_valid), 32'd0);
    check_output("mr_wr_en", 32'(ram_wr_en), 32'd0);
    check_reset_values();
    sreset = 1'b0;
    ptr    = '0;
    @(negedge clk);
    check_output("mr_wr_en_next", 32'(ram_wr_en), 32'd0);
    check_output("mr_ready_next", 32'(in_ready),  32'd1);
    foreach (post_vecs[i]) run_vec(post_vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
